restador: RTL and testbench

RESTADOR -- requirements
Module: restador

---
 rtl/restador.sv | 102 ++++++++++
 tb/tb_restador.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/restador.sv
// -----------------------------------------------------------------------------
// restador -- loadable down-counting accumulator with selectable subtrahend.
//
// A load preset fills the accumulator with all ones and starts the RUN state.
// While running, every edge subtracts the selected operand (nothing, data1,
// data2, or data1+data2). When the subtrahend exceeds the accumulator, an
// underflow occurs.
//
// Configuration macro: RESTADOR_AUTO_RELOAD_EN
//   undefined : an underflow stores the wrapped difference, moves the block to
//               HALT, and raises a sticky underflow flag.
//   defined   : an underflow reloads the accumulator with all ones, the block
//               stays in RUN, and the underflow flag is a one-cycle pulse.
// -----------------------------------------------------------------------------
module restador #(
   parameter int NB_DATA = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NB_DATA-1:0]     i_data1,
   input  logic [NB_DATA-1:0]     i_data2,
   input  logic [1:0]             i_sel,
   input  logic                   i_load,
   output logic [2*NB_DATA-1:0]   o_data,
   output logic                   o_underflow,
   output logic                   o_busy
);

   localparam int NB_ACC = 2 * NB_DATA;
   localparam logic [NB_ACC-1:0] ACC_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t              state;
   logic [NB_ACC-1:0]   acc;
   logic [NB_DATA:0]    operand_sum;
   logic [NB_ACC-1:0]   subtrahend;
   logic [NB_ACC-1:0]   difference;
   logic                underflow_now;

   // Pick the subtrahend for this edge, zero-extended to the accumulator width
   always_comb begin
      operand_sum = {1'b0, i_data1} + {1'b0, i_data2};
      subtrahend  = '0;
      case (i_sel)
         2'd0:    subtrahend = '0;
         2'd1:    subtrahend = NB_ACC'(i_data1);
         2'd2:    subtrahend = NB_ACC'(i_data2);
         default: subtrahend = NB_ACC'(operand_sum);
      endcase
      difference    = acc - subtrahend;
      underflow_now = (subtrahend > acc);
   end

   // Control FSM and accumulator; all outputs come straight from registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         o_underflow <= 1'b0;
         o_busy      <= 1'b0;
      end else if (i_load) begin
         state       <= RUN;
         acc         <= ACC_MAX;
         o_underflow <= 1'b0;
         o_busy      <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (underflow_now) begin
`ifdef RESTADOR_AUTO_RELOAD_EN
                  acc         <= ACC_MAX;
                  o_underflow <= 1'b1;
`else
                  acc         <= difference;
                  o_underflow <= 1'b1;
                  state       <= HALT;
                  o_busy      <= 1'b0;
`endif
               end else begin
                  acc         <= difference;
                  o_underflow <= 1'b0;
               end
            end
            IDLE, HALT: begin
               state <= state;
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

   assign o_data = acc;

endmodule

// File: tb/tb_restador.sv
// -----------------------------------------------------------------------------
// tb_restador -- self-checking bench for restador.
// Directed scenarios followed by a randomized run, all compared against an
// integer-arithmetic reference model. Honors RESTADOR_AUTO_RELOAD_EN.
// -----------------------------------------------------------------------------
module tb_restador;

   localparam int NB_DATA = 3;
   localparam int ACC_MAX = (1 << (2 * NB_DATA)) - 1;

   logic                   i_clk;
   logic                   i_rst_n;
   logic [NB_DATA-1:0]     i_data1;
   logic [NB_DATA-1:0]     i_data2;
   logic [1:0]             i_sel;
   logic                   i_load;
   logic [2*NB_DATA-1:0]   o_data;
   logic                   o_underflow;
   logic                   o_busy;

   int errors = 0;
   int checks = 0;

   int model_acc  = 0;
   bit model_busy = 0;
   bit model_uf   = 0;

   restador #(.NB_DATA(NB_DATA)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_data1     (i_data1),
      .i_data2     (i_data2),
      .i_sel       (i_sel),
      .i_load      (i_load),
      .o_data      (o_data),
      .o_underflow (o_underflow),
      .o_busy      (o_busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference model: one edge of behaviour in plain integer arithmetic
   task automatic modelStep(input bit load, input int sel, input int d1, input int d2);
      int sub;
      if (load) begin
         model_acc  = ACC_MAX;
         model_uf   = 0;
         model_busy = 1;
      end else if (model_busy) begin
         sub = (sel == 0) ? 0 : (sel == 1) ? d1 : (sel == 2) ? d2 : d1 + d2;
         if (sub > model_acc) begin
`ifdef RESTADOR_AUTO_RELOAD_EN
            model_acc = ACC_MAX;
            model_uf  = 1;
`else
            model_acc  = model_acc - sub + ACC_MAX + 1;
            model_uf   = 1;
            model_busy = 0;
`endif
         end else begin
            model_acc = model_acc - sub;
            model_uf  = 0;
         end
      end
   endtask

   task automatic modelReset();
      model_acc  = 0;
      model_busy = 0;
      model_uf   = 0;
   endtask

   // Compare all three outputs with the reference model
   task automatic checkOutput(input string tag);
      logic [2*NB_DATA-1:0] exp_data;
      exp_data = model_acc[2*NB_DATA-1:0];
      checks++;
      assert (o_data === exp_data) else begin
         errors++;
         $error("[TB] FAIL %s o_data observed=%0d expected=%0d", tag, o_data, exp_data);
      end
      checks++;
      assert (o_busy === model_busy) else begin
         errors++;
         $error("[TB] FAIL %s o_busy observed=%0b expected=%0b", tag, o_busy, model_busy);
      end
      checks++;
      assert (o_underflow === model_uf) else begin
         errors++;
         $error("[TB] FAIL %s o_underflow observed=%0b expected=%0b", tag, o_underflow, model_uf);
      end
   endtask

   // Compare one observed value with a fixed expectation
   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive one set of inputs, let an edge pass, and advance the model
   task automatic applyStimulus(input bit load, input logic [1:0] sel,
                                input logic [NB_DATA-1:0] d1, input logic [NB_DATA-1:0] d2);
      i_load  = load;
      i_sel   = sel;
      i_data1 = d1;
      i_data2 = d2;
      @(posedge i_clk);
      if (i_rst_n) modelStep(load, int'(sel), int'(d1), int'(d2));
      else         modelReset();
      #1;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_load  = 1'b0;
      i_sel   = 2'd0;
      i_data1 = '0;
      i_data2 = '0;

      // Reset held across edges while load is requested: nothing is sampled
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'd1, 3'd3, 3'd0);
         checkOutput("reset_hold");
      end
      checkValue("reset_data", 32'(o_data), 32'd0);

      // Release and idle for 10 cycles
      i_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 2'd1, 3'd3, 3'd5);
         checkOutput("idle_after_reset");
      end
      checkValue("idle_busy", 32'(o_busy), 32'd0);

      // Load then subtract 3 per edge down to zero
      applyStimulus(1'b1, 2'd1, 3'd3, 3'd0);
      checkOutput("load_sel1");
      checkValue("load_value", 32'(o_data), 32'd63);
      for (int i = 1; i <= 21; i++) begin
         applyStimulus(1'b0, 2'd1, 3'd3, 3'd0);
         checkOutput("count_sel1");
      end
      checkValue("edge21_zero", 32'(o_data), 32'd0);
      applyStimulus(1'b0, 2'd1, 3'd3, 3'd0);
      checkOutput("edge22_underflow");
`ifdef RESTADOR_AUTO_RELOAD_EN
      checkValue("edge22_data", 32'(o_data), 32'd63);
      checkValue("edge22_busy", 32'(o_busy), 32'd1);
`else
      checkValue("edge22_data", 32'(o_data), 32'd61);
      checkValue("edge22_busy", 32'(o_busy), 32'd0);
`endif
      checkValue("edge22_uf", 32'(o_underflow), 32'd1);
      applyStimulus(1'b0, 2'd1, 3'd3, 3'd0);
      checkOutput("edge23_after_uf");
`ifdef RESTADOR_AUTO_RELOAD_EN
      checkValue("edge23_uf_pulse", 32'(o_underflow), 32'd0);
`else
      checkValue("edge23_uf_sticky", 32'(o_underflow), 32'd1);
      checkValue("edge23_halt_hold", 32'(o_data), 32'd61);
`endif

      // Load from HALT (or from RUN in the auto-reload build)
      applyStimulus(1'b1, 2'd3, 3'd1, 3'd1);
      checkOutput("reload");
      checkValue("reload_data", 32'(o_data), 32'd63);
      checkValue("reload_busy", 32'(o_busy), 32'd1);
      checkValue("reload_uf", 32'(o_underflow), 32'd0);

      // Subtract data1+data2 = 2 per edge
      for (int i = 1; i <= 31; i++) begin
         applyStimulus(1'b0, 2'd3, 3'd1, 3'd1);
         checkOutput("count_sel3");
      end
      checkValue("edge31_one", 32'(o_data), 32'd1);
      applyStimulus(1'b0, 2'd3, 3'd1, 3'd1);
      checkOutput("edge32_underflow");
      checkValue("edge32_data", 32'(o_data), 32'd63);
      checkValue("edge32_uf", 32'(o_underflow), 32'd1);

      // Hold with sel=0 for 20 cycles
      applyStimulus(1'b1, 2'd0, 3'd7, 3'd7);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 2'd0, 3'd7, 3'd7);
         checkOutput("hold_sel0");
      end
      checkValue("hold_data", 32'(o_data), 32'd63);

      // Exact-equality subtraction reaches zero without underflow
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 2'd2, 3'd0, 3'd7);
         checkOutput("count_sel2");
      end
      checkValue("sel2_at7", 32'(o_data), 32'd7);
      applyStimulus(1'b0, 2'd2, 3'd0, 3'd7);
      checkOutput("equal_to_zero");
      checkValue("equal_zero_data", 32'(o_data), 32'd0);
      checkValue("equal_zero_uf", 32'(o_underflow), 32'd0);

      // Asynchronous reset mid-RUN at o_data=30
      applyStimulus(1'b1, 2'd1, 3'd3, 3'd0);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b0, 2'd1, 3'd3, 3'd0);
      end
      checkValue("pre_reset_30", 32'(o_data), 32'd30);
      #2;
      i_rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset");
      checkValue("async_reset_data", 32'(o_data), 32'd0);
      checkValue("async_reset_busy", 32'(o_busy), 32'd0);
      applyStimulus(1'b0, 2'd1, 3'd3, 3'd0);
      i_rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 2'd1, 3'd3, 3'd0);
         checkOutput("idle_after_abort");
      end

      // Randomized run against the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 11) == 0),
                       2'($urandom_range(0, 3)),
                       3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)));
         checkOutput("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
